// File: rtl/uart_burst_reg_bridge_pkg.sv
// Shared types and constants for the uart burst register bridge.
// Holds the FSM state encoding, the header layout, the ACK byte and width helpers.
package uart_burst_reg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_ACK     = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_SEND = 3'd6
    } state_t;

    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam int         HDR_RD_BIT = 32'sd7;

    function automatic int clog2_int(input int value);
        int w;
        w = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 32'sd1;
            end
        end
        return w;
    endfunction

    function automatic int addr_bytes(input int width);
        return (width + 32'sd7) / 32'sd8;
    endfunction

endpackage

// File: rtl/uart_burst_reg_bridge_timeout.sv
// Inter-byte watchdog. It counts idle cycles while enabled and flags expiry on the
// cycle that completes the limit. A limit of zero means the watchdog never fires.
module uart_burst_reg_bridge_timeout #(
    parameter int TimeoutCycles = 1562500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CntW = (TimeoutCycles < 32'sd1) ? 32'sd1 : $clog2(TimeoutCycles + 32'sd1);
    localparam logic [CntW-1:0] LastCnt = (TimeoutCycles == 32'sd0) ? '0 : CntW'(TimeoutCycles - 32'sd1);

    logic [CntW-1:0] cnt_r;

    // Idle-cycle counter, restarted by every accepted byte or when not watching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (count_en) begin
            cnt_r <= cnt_r + CntW'(1);
        end
    end

    assign expire = (TimeoutCycles != 32'sd0) && count_en && (cnt_r == LastCnt);

endmodule

// File: rtl/uart_burst_reg_bridge.sv
// Byte-stream command engine: header, MSB-first address, then a burst of writes
// (answered with ACK) or reads (each returned as a tx byte), with address auto-increment.
module uart_burst_reg_bridge
    import uart_burst_reg_bridge_pkg::*;
#(
    parameter int DataSize      = 8,
    parameter int AddrWidth     = 7,
    parameter int MaxBurst      = 16,
    parameter int TimeoutCycles = 1562500
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DataSize-1:0]  i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    output logic [DataSize-1:0]  o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [AddrWidth-1:0] o_reg_addr,
    output logic                 o_reg_wr_en,
    output logic [DataSize-1:0]  o_reg_wdata,
    output logic                 o_reg_rd_en,
    input  logic [DataSize-1:0]  i_reg_rdata,
    output logic                 o_busy,
    output logic                 o_err_timeout
);

    localparam int         LenW   = clog2_int(MaxBurst);
    localparam logic [1:0] AbLast = 2'(addr_bytes(AddrWidth) - 32'sd1);

    state_t               state_r;
    logic                 rd_wrn_r;
    logic [LenW-1:0]      len_m1_r;
    logic [LenW-1:0]      idx_r;
    logic [1:0]           ab_r;
    logic [AddrWidth-1:0] addr_r;
    logic [AddrWidth-1:0] addr_next_s;
    logic                 rx_acc_s;
    logic                 tx_acc_s;
    logic                 tmo_active_s;
    logic                 expire_s;
    logic                 last_s;

    assign rx_acc_s     = i_rx_valid && o_rx_ready;
    assign tx_acc_s     = o_tx_valid && i_tx_ready;
    assign tmo_active_s = (state_r == ST_ADDR) || (state_r == ST_WDATA);
    assign last_s       = (idx_r == len_m1_r);

    // Shifting in a new address byte drops whatever falls above AddrWidth.
    if (AddrWidth > DataSize) begin : g_addr_wide
        assign addr_next_s = {addr_r[AddrWidth-DataSize-1:0], i_rx_data};
    end else begin : g_addr_narrow
        assign addr_next_s = i_rx_data[AddrWidth-1:0];
    end

    uart_burst_reg_bridge_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clear    (!tmo_active_s || rx_acc_s),
        .count_en (tmo_active_s && !rx_acc_s),
        .expire   (expire_s)
    );

    // Command FSM with burst counters and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_HDR;
            rd_wrn_r      <= 1'b0;
            len_m1_r      <= '0;
            idx_r         <= '0;
            ab_r          <= 2'd0;
            addr_r        <= '0;
            o_rx_ready    <= 1'b0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_reg_addr    <= '0;
            o_reg_wr_en   <= 1'b0;
            o_reg_wdata   <= '0;
            o_reg_rd_en   <= 1'b0;
            o_busy        <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            o_reg_wr_en   <= 1'b0;
            o_reg_rd_en   <= 1'b0;
            o_err_timeout <= 1'b0;
            case (state_r)
                ST_HDR: begin
                    o_rx_ready <= 1'b1;
                    if (rx_acc_s) begin
                        rd_wrn_r <= i_rx_data[HDR_RD_BIT];
                        len_m1_r <= i_rx_data[LenW-1:0];
                        idx_r    <= '0;
                        ab_r     <= 2'd0;
                        addr_r   <= '0;
                        o_busy   <= 1'b1;
                        state_r  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (expire_s) begin
                        o_err_timeout <= 1'b1;
                        o_busy        <= 1'b0;
                        state_r       <= ST_HDR;
                    end else if (rx_acc_s) begin
                        addr_r <= addr_next_s;
                        ab_r   <= ab_r + 2'd1;
                        if (ab_r == AbLast) begin
                            if (rd_wrn_r) begin
                                o_rx_ready  <= 1'b0;
                                o_reg_rd_en <= 1'b1;
                                o_reg_addr  <= addr_next_s;
                                state_r     <= ST_RD_REQ;
                            end else begin
                                state_r <= ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (expire_s) begin
                        o_err_timeout <= 1'b1;
                        o_busy        <= 1'b0;
                        state_r       <= ST_HDR;
                    end else if (rx_acc_s) begin
                        o_reg_wr_en <= 1'b1;
                        o_reg_wdata <= i_rx_data;
                        o_reg_addr  <= addr_r;
                        addr_r      <= addr_r + AddrWidth'(1);
                        idx_r       <= idx_r + LenW'(1);
                        if (last_s) begin
                            o_rx_ready <= 1'b0;
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= DataSize'(ACK_BYTE);
                            state_r    <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (tx_acc_s) begin
                        o_tx_valid <= 1'b0;
                        o_busy     <= 1'b0;
                        o_rx_ready <= 1'b1;
                        state_r    <= ST_HDR;
                    end
                end
                ST_RD_REQ: begin
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    o_tx_data  <= i_reg_rdata;
                    o_tx_valid <= 1'b1;
                    state_r    <= ST_RD_SEND;
                end
                ST_RD_SEND: begin
                    if (tx_acc_s) begin
                        o_tx_valid <= 1'b0;
                        addr_r     <= addr_r + AddrWidth'(1);
                        if (last_s) begin
                            o_busy     <= 1'b0;
                            o_rx_ready <= 1'b1;
                            state_r    <= ST_HDR;
                        end else begin
                            idx_r       <= idx_r + LenW'(1);
                            o_reg_rd_en <= 1'b1;
                            o_reg_addr  <= addr_r + AddrWidth'(1);
                            state_r     <= ST_RD_REQ;
                        end
                    end
                end
                default: begin
                    o_rx_ready <= 1'b0;
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    state_r    <= ST_HDR;
                end
            endcase
        end
    end

endmodule
